// File: rtl/conv_pass_sched_pkg.sv
// Shared types and helpers for the multi-pass convolution scheduler.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        NEXT
    } state_t;

    localparam logic [1:0] FIL_ID    = 2'd0;
    localparam logic [1:0] FIL_EDGE  = 2'd1;
    localparam logic [1:0] FIL_BLUR  = 2'd2;
    localparam logic [1:0] FIL_SHARP = 2'd3;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 500;

    // Pixels streamed into the convolution unit per pass.
    function automatic int n_in(input int w, input int h);
        return w * h;
    endfunction

    // Valid 3x3 results produced per pass (no padding).
    function automatic int n_out(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

    // Filter code for pass p out of the packed per-pass sequence.
    function automatic logic [1:0] fil_of(input logic [7:0] seq, input logic [1:0] p);
        return seq[2*p +: 2];
    endfunction

endpackage

// File: rtl/conv_pass_sched_prefetch_buf.sv
// Two-entry pixel prefetch buffer. Memory returns data exactly one cycle
// after the read strobe, so one in-flight flag is enough to track it. The
// read strobe is combinational so a pop can free a slot for a read in the
// same cycle, keeping one pixel per cycle once primed.
module conv_prefetch_buf (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       en,
    input  logic       more,
    input  logic [7:0] rd_data,
    input  logic       req,
    output logic       rd_en,
    output logic       pop,
    output logic       empty,
    output logic [7:0] head
);
    logic [1:0] cnt;
    logic       ret_v;
    logic [7:0] e1;
    logic [2:0] tok;

    assign empty = (cnt == 2'd0);
    assign pop   = en && req && !empty;
    // Entries held plus the read landing now, less what leaves this cycle.
    assign tok   = {1'b0, cnt} + {2'b0, ret_v} - {2'b0, pop};
    assign rd_en = en && more && (tok < 3'd2);

    // Capture returning reads and shift the head on pops.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            ret_v <= 1'b0;
            head  <= 8'd0;
            e1    <= 8'd0;
        end else if (flush) begin
            cnt   <= 2'd0;
            ret_v <= 1'b0;
        end else begin
            ret_v <= rd_en;
            unique case ({ret_v, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= rd_data;
                    else             e1   <= rd_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // Last entry leaving: head keeps showing the old pixel.
                    if (cnt == 2'd2) head <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) head <= rd_data;
                    else begin
                        head <= e1;
                        e1   <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_pass_sched.sv
// Multi-pass 3x3 convolution scheduler: streams a frame bank into the
// convolution unit, writes results to the other bank, chains up to 4 passes.
// Optional watchdog: define CONV_SCHED_WDOG_EN.
module conv_pass_sched
    import conv_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int CLR_CYC = 4,
    parameter int ADDR_W  = 19
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        npass_i,
    input  logic [7:0]        fil_seq_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        pass_o,
    output logic              rd_bank_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              conv_rst_o,
    output logic [1:0]        fil_sw_o,
    output logic [7:0]        pixel_o,
    input  logic              conv_req_i,
    input  logic              conv_v_i,
    input  logic [7:0]        conv_data_i,
    input  logic              conv_fin_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);
    // Counters carry one extra bit so a full 2^ADDR_W frame still compares.
    localparam logic [ADDR_W:0] N_IN_M1  = (ADDR_W+1)'(n_in(IMG_W, IMG_H) - 1);
    localparam logic [ADDR_W:0] N_IN_C   = (ADDR_W+1)'(n_in(IMG_W, IMG_H));
    localparam logic [ADDR_W:0] N_OUT_C  = (ADDR_W+1)'(n_out(IMG_W, IMG_H));
    localparam logic [ADDR_W:0] N_OUT_M1 = (ADDR_W+1)'(n_out(IMG_W, IMG_H) - 1);
    localparam logic [7:0]      CLR_LAST = 8'(CLR_CYC - 1);

    state_t          state;
    logic [1:0]      npass_q;
    logic [7:0]      fil_q;
    logic [7:0]      clr_cnt;
    logic [ADDR_W:0] rd_cnt;
    logic [ADDR_W:0] pop_cnt;
    logic [ADDR_W:0] out_cnt;
    logic            pop;
    logic            buf_empty;
    logic            writing;
`ifdef CONV_SCHED_WDOG_EN
    logic [15:0]     wdog;
`endif

    assign rd_addr_o = rd_cnt[ADDR_W-1:0];
    assign writing   = (state == STREAM) || (state == DRAIN);

    conv_prefetch_buf u_buf (
        .clk_i   (clk_i),
        .rst_n   (reset_i),
        .flush   (state == CLEAR),
        .en      (state == STREAM),
        .more    (rd_cnt < N_IN_C),
        .rd_data (rd_data_i),
        .req     (conv_req_i),
        .rd_en   (rd_en_o),
        .pop     (pop),
        .empty   (buf_empty),
        .head    (pixel_o)
    );

    // Pass sequencing FSM with registered outputs, plus result writeback.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            npass_q    <= 2'd0;
            fil_q      <= 8'd0;
            clr_cnt    <= 8'd0;
            rd_cnt     <= '0;
            pop_cnt    <= '0;
            out_cnt    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            pass_o     <= 2'd0;
            rd_bank_o  <= 1'b0;
            conv_rst_o <= 1'b0;
            fil_sw_o   <= FIL_ID;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= 8'd0;
`ifdef CONV_SCHED_WDOG_EN
            wdog       <= 16'd0;
`endif
        end else begin
            done_o  <= 1'b0;
            wr_en_o <= 1'b0;
            if (rd_en_o) rd_cnt  <= rd_cnt + 1'b1;
            if (pop)     pop_cnt <= pop_cnt + 1'b1;

            if (writing && conv_v_i) begin
                if (out_cnt < N_OUT_C) begin
                    wr_en_o   <= 1'b1;
                    wr_addr_o <= out_cnt[ADDR_W-1:0];
                    wr_data_o <= conv_data_i;
                    out_cnt   <= out_cnt + 1'b1;
                end else begin
                    err_o <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    conv_rst_o <= 1'b0;
                    if (start_i) begin
                        npass_q   <= npass_i;
                        fil_q     <= fil_seq_i;
                        fil_sw_o  <= fil_of(fil_seq_i, 2'd0);
                        err_o     <= 1'b0;
                        pass_o    <= 2'd0;
                        rd_bank_o <= 1'b0;
                        busy_o    <= 1'b1;
                        clr_cnt   <= 8'd0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    conv_rst_o <= 1'b0;
                    rd_cnt     <= '0;
                    pop_cnt    <= '0;
                    out_cnt    <= '0;
                    clr_cnt    <= clr_cnt + 8'd1;
                    if (clr_cnt == CLR_LAST) begin
                        conv_rst_o <= 1'b1;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (conv_req_i && buf_empty) err_o <= 1'b1;
                    if (pop && pop_cnt == N_IN_M1) state <= DRAIN;
                end
                DRAIN: begin
                    // A result landing now that completes the frame counts.
                    if (out_cnt == N_OUT_C || (conv_v_i && out_cnt == N_OUT_M1)) begin
                        state <= NEXT;
                    end else if (conv_fin_i) begin
                        err_o <= 1'b1;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    conv_rst_o <= 1'b0;
                    if (pass_o == npass_q) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        pass_o    <= pass_o + 2'd1;
                        rd_bank_o <= ~rd_bank_o;
                        fil_sw_o  <= fil_of(fil_q, pass_o + 2'd1);
                        clr_cnt   <= 8'd0;
                        state     <= CLEAR;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef CONV_SCHED_WDOG_EN
            // Stall timeout: abort to IDLE; conv unit stays in reset there.
            if ((state == STREAM && pop) || (state == DRAIN && conv_v_i) || !writing) begin
                wdog <= 16'd0;
            end else begin
                wdog <= wdog + 16'd1;
            end
            if (writing && wdog == 16'hFFFF) begin
                err_o      <= 1'b1;
                conv_rst_o <= 1'b0;
                done_o     <= 1'b1;
                busy_o     <= 1'b0;
                state      <= IDLE;
            end
`endif
        end
    end

endmodule
